ahb_rr_arbiter: RTL and testbench



---
 rtl/ahb_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_ahb_rr_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_rr_arbiter.sv
// rtl/ahb_rr_arbiter.sv - round-robin AHB-Lite arbiter with fixed-burst locking and data-phase owner tracking
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int MAX_HOLD    = 16,
    parameter int SEL_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic                   HRESP,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [SEL_W-1:0]       addr_sel,
    output logic [SEL_W-1:0]       data_sel,
    output logic                   locked
);

    localparam logic [1:0] ST_PARK   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_BURST  = 2'd2;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_SINGLE = 3'b000;

    logic [1:0]       state, state_nxt;
    logic [SEL_W-1:0] addr_sel_nxt, rr_winner;
    logic [4:0]       beat_cnt, beat_nxt, beat_load;
    logic [7:0]       hold_cnt, hold_nxt;
    logic             others_req, rr_found, fixed_start, last_beat, rearb;
    int               idx;

    always_comb begin
        others_req = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (i != int'(addr_sel) && req[i]) others_req = 1'b1;
        end
    end

    // Search begins one past the owner and wraps, so the owner itself is checked last.
    always_comb begin
        rr_winner = addr_sel;
        rr_found  = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(addr_sel) + k) % NUM_MASTERS;
            if (!rr_found && req[idx]) begin
                rr_winner = SEL_W'(idx);
                rr_found  = 1'b1;
            end
        end
    end

    always_comb begin
        case (HBURST[2:1])
            2'b01:   beat_load = 5'd3;
            2'b10:   beat_load = 5'd7;
            2'b11:   beat_load = 5'd15;
            default: beat_load = 5'd0;
        endcase
    end

    assign fixed_start = (HTRANS == TR_NONSEQ) && (HBURST[2:1] != 2'b00);
    // The counter holds the SEQ beats still owed; the SEQ that takes it to zero ends the burst.
    assign last_beat   = (HTRANS == TR_SEQ) && (beat_cnt == 5'd1);

    always_comb begin
        case (state)
            ST_GRANT: rearb = !req[addr_sel] || (HTRANS == TR_IDLE) ||
                              ((HTRANS == TR_NONSEQ) && (HBURST == BU_SINGLE)) ||
                              (hold_cnt == 8'(MAX_HOLD));
            ST_BURST: rearb = last_beat || HRESP;
            default:  rearb = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        addr_sel_nxt = addr_sel;
        beat_nxt     = beat_cnt;
        hold_nxt     = 8'd0;
        if (rearb) begin
            if (rr_found) begin
                addr_sel_nxt = rr_winner;
                state_nxt    = ST_GRANT;
            end else begin
                state_nxt    = ST_PARK;
            end
        end else if (fixed_start) begin
            state_nxt = ST_BURST;
            beat_nxt  = beat_load;
        end else if (state == ST_BURST && HTRANS == TR_SEQ) begin
            beat_nxt  = beat_cnt - 5'd1;
        end
        if (state == ST_GRANT && state_nxt == ST_GRANT && addr_sel_nxt == addr_sel && others_req) begin
            hold_nxt = (hold_cnt == 8'(MAX_HOLD)) ? hold_cnt : hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_PARK;
            addr_sel <= '0;
            data_sel <= '0;
            beat_cnt <= 5'd0;
            hold_cnt <= 8'd0;
        end else if (HREADY) begin
            state    <= state_nxt;
            addr_sel <= addr_sel_nxt;
            data_sel <= addr_sel;
            beat_cnt <= beat_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        grant           = '0;
        grant[addr_sel] = 1'b1;
    end

    assign locked = (state == ST_BURST);

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb/tb_ahb_rr_arbiter.sv - scoreboard bench for ahb_rr_arbiter against a behavioural arbitration model
module tb_ahb_rr_arbiter;

    localparam int N  = 3;
    localparam int MH = 4;
    localparam int SW = $clog2(N);

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b1;
    logic [N-1:0]  req = '0;
    logic [1:0]    HTRANS = 2'b00;
    logic [2:0]    HBURST = 3'b000;
    logic          HREADY = 1'b1;
    logic          HRESP = 1'b0;
    logic [N-1:0]  grant;
    logic [SW-1:0] addr_sel;
    logic [SW-1:0] data_sel;
    logic          locked;

    ahb_rr_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MH)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .HTRANS(HTRANS), .HBURST(HBURST),
        .HREADY(HREADY), .HRESP(HRESP), .grant(grant), .addr_sel(addr_sel),
        .data_sel(data_sel), .locked(locked)
    );

    always #5 HCLK = ~HCLK;

    typedef struct { int owner; int dsel; bit lock; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who owns the bus, whether idle-parked, whether locked in a burst.
    int m_owner, m_dsel, m_beats_left, m_hold;
    bit m_parked, m_burst;

    task automatic check(string name, int act, int want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, want);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_dsel = 0; m_beats_left = 0; m_hold = 0;
        m_parked = 1'b1; m_burst = 1'b0;
    endtask

    task automatic model_edge();
        bit others, rearb, nonseq, seq, was_grant;
        int nxt, w, len;
        if (HREADY) begin
            others = 1'b0;
            for (int i = 0; i < N; i++) if (i != m_owner && req[i]) others = 1'b1;
            nonseq    = (HTRANS == 2'b10);
            seq       = (HTRANS == 2'b11);
            was_grant = !m_parked && !m_burst;
            if (m_parked)     rearb = 1'b1;
            else if (m_burst) rearb = (seq && m_beats_left == 1) || HRESP;
            else              rearb = !req[m_owner] || HTRANS == 2'b00 ||
                                      (nonseq && HBURST == 3'b000) || m_hold == MH;
            m_dsel = m_owner;
            nxt = m_owner;
            if (rearb) begin
                w = -1;
                for (int k = 1; k <= N; k++) if (w < 0 && req[(m_owner + k) % N]) w = (m_owner + k) % N;
                m_burst  = 1'b0;
                m_parked = (w < 0);
                if (w >= 0) nxt = w;
            end else if (nonseq && HBURST >= 3'd2) begin
                len = 4 << (int'(HBURST >> 1) - 1);
                m_burst = 1'b1;
                m_beats_left = len - 1;
            end else if (m_burst && seq) begin
                m_beats_left--;
            end
            if (was_grant && !m_parked && !m_burst && nxt == m_owner && others)
                m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
            else
                m_hold = 0;
            m_owner = nxt;
        end
        exp_q.push_back('{m_owner, m_dsel, m_burst});
    endtask

    task automatic step(logic [N-1:0] r, logic [1:0] t, logic [2:0] b, logic rdy, logic rsp);
        @(negedge HCLK);
        req = r; HTRANS = t; HBURST = b; HREADY = rdy; HRESP = rsp;
        @(posedge HCLK);
        if (HRESETn) model_edge();
    endtask

    // Asserts reset between edges and checks the outputs fall back without waiting for a clock.
    task automatic do_reset();
        #3;
        HRESETn = 1'b0;
        req = '0; HTRANS = 2'b00; HBURST = 3'b000; HREADY = 1'b1; HRESP = 1'b0;
        #1;
        check("rst_grant", int'(grant), 1);
        check("rst_addr_sel", int'(addr_sel), 0);
        check("rst_data_sel", int'(data_sel), 0);
        check("rst_locked", int'(locked), 0);
        model_reset();
        @(posedge HCLK);
        #3;
        HRESETn = 1'b1;
    endtask

    task automatic rand_run(int cycles);
        logic [N-1:0] r;
        logic [1:0]   t;
        logic [2:0]   b;
        logic         rdy, rsp;
        int           sel;
        r = '0;
        for (int n = 0; n < cycles; n++) begin
            if ($urandom_range(0, 9) < 3) r = N'($urandom_range(0, (1 << N) - 1));
            if (m_burst) begin
                sel = $urandom_range(0, 9);
                t = (sel < 7) ? 2'b11 : (sel < 9) ? 2'b01 : 2'b10;
            end else begin
                t = 2'($urandom_range(0, 3));
            end
            b   = 3'($urandom_range(0, 7));
            rdy = ($urandom_range(0, 6) != 0);
            rsp = ($urandom_range(0, 29) == 0);
            step(r, t, b, rdy, rsp);
            if ($urandom_range(0, 249) == 0) do_reset();
        end
    endtask

    initial begin
        forever begin
            @(posedge HCLK);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("grant", int'(grant), 1 << mon_e.owner);
                check("addr_sel", int'(addr_sel), mon_e.owner);
                check("data_sel", int'(data_sel), mon_e.dsel);
                check("locked", int'(locked), int'(mon_e.lock));
            end
        end
    end

    initial begin
        model_reset();
        #1;
        do_reset();
        for (int i = 0; i < 5; i++) step('0, 2'b00, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(3'b011, 2'b10, 3'b000, 1'b1, 1'b0);
        // INCR8 from master 0 with a BUSY and a three-cycle stall inside the burst.
        step(3'b011, 2'b10, 3'b101, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i == 2)      step(3'b011, 2'b01, 3'b101, 1'b1, 1'b0);
            else if (i == 3) for (int s = 0; s < 3; s++) step(3'b011, 2'b11, 3'b101, 1'b0, 1'b0);
            step(3'b011, 2'b11, 3'b101, 1'b1, 1'b0);
        end
        // Undefined-length INCR held past the hold limit while another master waits.
        step(3'b011, 2'b10, 3'b001, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(3'b011, 2'b11, 3'b001, 1'b1, 1'b0);
        // WRAP4 aborted by an error response, then a second WRAP4 cut short by reset.
        step(3'b011, 2'b10, 3'b010, 1'b1, 1'b0);
        step(3'b011, 2'b11, 3'b010, 1'b1, 1'b0);
        step(3'b011, 2'b11, 3'b010, 1'b1, 1'b1);
        step(3'b011, 2'b10, 3'b010, 1'b1, 1'b0);
        step(3'b011, 2'b11, 3'b010, 1'b1, 1'b0);
        do_reset();
        step(3'b110, 2'b10, 3'b000, 1'b1, 1'b0);
        step(3'b111, 2'b10, 3'b000, 1'b1, 1'b0);
        rand_run(3000);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
